// File: rtl/sgdmac_pkg.sv
// sgdmac_pkg: shared types and helpers for the SGDMAC arbiter slice.
package sgdmac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Channel-id width that stays at least 1 bit for a single channel
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sgdmac_skid_buf.sv
// sgdmac_skid_buf: 2-entry FIFO; entry 0 is always the head, so the
// output payload comes straight from a register.
module sgdmac_skid_buf #(
  parameter int unsigned W = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] ent0_q;
  logic [W-1:0] ent1_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = ent0_q;

  // Shift-style storage: pops move entry 1 to the head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else if (do_push && !do_pop) begin
      if (cnt_q == 2'd0) ent0_q <= push_data;
      else               ent1_q <= push_data;
      cnt_q <= cnt_q + 2'd1;
    end else if (!do_push && do_pop) begin
      ent0_q <= ent1_q;
      cnt_q  <= cnt_q - 2'd1;
    end else if (do_push && do_pop) begin
      if (cnt_q == 2'd1) begin
        ent0_q <= push_data;
      end else begin
        ent0_q <= ent1_q;
        ent1_q <= push_data;
      end
    end
  end

endmodule

// File: rtl/sgdmac_rr_arbiter.sv
// sgdmac_rr_arbiter: N-channel round-robin packet arbiter with the grant
// locked until `last`, output registered through a 2-entry skid buffer.
// Optional feature macro: SGDMAC_ARB_PRIO_EN (adds src_prio_i).
module sgdmac_rr_arbiter
  import sgdmac_pkg::*;
#(
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned DATA_SIZE = 32,
  localparam int unsigned CH_W      = ch_width(N_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           src_valid_i,
  output logic [N_CH-1:0]           src_ready_o,
  input  logic [N_CH*DATA_SIZE-1:0] src_data_i,
  input  logic [N_CH-1:0]           src_last_i,
  output logic                      dst_valid_o,
  input  logic                      dst_ready_i,
  output logic [DATA_SIZE-1:0]      dst_data_o,
  output logic                      dst_last_o,
  output logic [CH_W-1:0]           dst_ch_o
`ifdef SGDMAC_ARB_PRIO_EN
  ,
  input  logic [N_CH-1:0]           src_prio_i
`endif
);

  localparam int unsigned PW = DATA_SIZE + 1 + CH_W;

  arb_state_e             state_q;
  logic [CH_W-1:0]        grant_q;
  logic [CH_W-1:0]        rr_ptr_q;
  logic [N_CH-1:0]        req;
  logic [DATA_SIZE-1:0]   grant_data;
  logic                   grant_last;
  logic                   accept;
  logic                   buf_full;
  logic                   buf_empty;
  logic [PW-1:0]          buf_head;

  // First requesting channel searching upward from ptr, wrapping to 0
  function automatic logic [CH_W-1:0] rr_find(input logic [N_CH-1:0] r,
                                               input logic [CH_W-1:0] ptr);
    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] cand;
    logic            found;
    int unsigned     idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx  = (i + 32'(ptr)) % N_CH;
      cand = CH_W'(idx);
      if (!found && r[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return sel;
  endfunction

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] g);
    return (32'(g) == N_CH - 1) ? '0 : g + CH_W'(1);
  endfunction

  // Request set: prioritised channels win the search when any is valid
  always_comb begin
    req = src_valid_i;
`ifdef SGDMAC_ARB_PRIO_EN
    if (|(src_valid_i & src_prio_i)) req = src_valid_i & src_prio_i;
`endif
  end

  // Payload mux for the granted channel
  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (CH_W'(k) == grant_q) grant_data = src_data_i[k*DATA_SIZE +: DATA_SIZE];
    end
  end

  assign grant_last = src_last_i[grant_q];
  assign accept     = (state_q == LOCK) & src_valid_i[grant_q] & ~buf_full;

  // Ready only for the held grant, from registered state alone
  always_comb begin
    src_ready_o = '0;
    if (state_q == LOCK && !buf_full) src_ready_o[grant_q] = 1'b1;
  end

  // Arbitration FSM: pick in IDLE, hold until the last beat is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|src_valid_i) begin
            state_q <= LOCK;
            grant_q <= rr_find(req, rr_ptr_q);
          end
        end
        LOCK: begin
          if (accept && grant_last) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ch(grant_q);
          end
        end
      endcase
    end
  end

  sgdmac_skid_buf #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_data({grant_last, grant_data, grant_q}),
    .pop      (dst_valid_o & dst_ready_i),
    .pop_data (buf_head),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign dst_valid_o                        = ~buf_empty;
  assign {dst_last_o, dst_data_o, dst_ch_o} = buf_head;

endmodule

// File: tb/tb_sgdmac_rr_arbiter.sv
// tb_sgdmac_rr_arbiter: directed scenarios plus randomized packet traffic
// checked against a packet-level round-robin reference model.
module tb_sgdmac_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    src_valid_i;
  logic [N-1:0]    src_ready_o;
  logic [N*DW-1:0] src_data_i;
  logic [N-1:0]    src_last_i;
  logic            dst_valid_o;
  logic            dst_ready_i;
  logic [DW-1:0]   dst_data_o;
  logic            dst_last_o;
  logic [1:0]      dst_ch_o;
`ifdef SGDMAC_ARB_PRIO_EN
  logic [N-1:0]    src_prio_i;
`endif

  always #5 clk = ~clk;

  sgdmac_rr_arbiter #(
    .N_CH     (N),
    .DATA_SIZE(DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid_i(src_valid_i),
    .src_ready_o(src_ready_o),
    .src_data_i (src_data_i),
    .src_last_i (src_last_i),
    .dst_valid_o(dst_valid_o),
    .dst_ready_i(dst_ready_i),
    .dst_data_o (dst_data_o),
    .dst_last_o (dst_last_o),
    .dst_ch_o   (dst_ch_o)
`ifdef SGDMAC_ARB_PRIO_EN
    ,
    .src_prio_i (src_prio_i)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Source model: per-channel beat queues, bit DW is `last`
  logic [DW:0]  srcq [N][$];
  bit           hold [N];
  bit           mid  [N];
  int           acc_cnt [N];
  int           acc_order [$];
  bit           gap_en;
  logic [N-1:0] rdy_seen;
  int           cap_ch   [$];
  bit           cap_last [$];
  logic [DW-1:0] cap_data [$];

  task automatic clear_tb();
    for (int c = 0; c < N; c++) begin
      srcq[c].delete();
      hold[c]    = 1'b0;
      mid[c]     = 1'b0;
      acc_cnt[c] = 0;
    end
    acc_order.delete();
    cap_ch.delete();
    cap_last.delete();
    cap_data.delete();
    gap_en      = 1'b0;
    rdy_seen    = '0;
    src_valid_i = '0;
    src_last_i  = '0;
    src_data_i  = '0;
    dst_ready_i = 1'b1;
`ifdef SGDMAC_ARB_PRIO_EN
    src_prio_i  = '0;
`endif
  endtask

  task automatic do_reset();
    clear_tb();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_beat(input int c, input bit last, input logic [DW-1:0] d);
    srcq[c].push_back({last, d});
  endtask

  // One clock: drive sources, sample handshakes mid-cycle, retire beats
  task automatic step();
    logic [N-1:0] acc;
    logic [DW:0]  beat;
    for (int c = 0; c < N; c++) begin
      bit v;
      v = (srcq[c].size() > 0) && !hold[c] &&
          !(gap_en && mid[c] && ($urandom_range(0, 3) == 0));
      src_valid_i[c] = v;
      if (srcq[c].size() > 0) begin
        beat = srcq[c][0];
        src_data_i[c*DW +: DW] = beat[DW-1:0];
        src_last_i[c]          = beat[DW];
      end else begin
        src_data_i[c*DW +: DW] = '0;
        src_last_i[c]          = 1'b0;
      end
    end
    #3;
    rdy_seen = src_ready_o;
    acc      = src_valid_i & src_ready_o;
    if (dst_valid_o && dst_ready_i) begin
      cap_ch.push_back(int'(dst_ch_o));
      cap_last.push_back(dst_last_o);
      cap_data.push_back(dst_data_o);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (acc[c]) begin
        beat = srcq[c].pop_front();
        acc_cnt[c]++;
        acc_order.push_back(c);
        mid[c] = !beat[DW];
      end
    end
  endtask

  task automatic test_reset();
    clear_tb();
    src_valid_i = '1;
    rst_n = 1'b0;
    #2;
    compared++; if (src_ready_o !== '0) begin mismatched++; $display("FAIL reset_src_ready got %b want 0000", src_ready_o); end
    compared++; if (dst_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_dst_valid got %b want 0", dst_valid_o); end
    compared++; if (dst_data_o !== '0) begin mismatched++; $display("FAIL reset_dst_data got %h want 0", dst_data_o); end
    compared++; if (dst_last_o !== 1'b0) begin mismatched++; $display("FAIL reset_dst_last got %b want 0", dst_last_o); end
    compared++; if (dst_ch_o !== '0) begin mismatched++; $display("FAIL reset_dst_ch got %0d want 0", dst_ch_o); end
    @(posedge clk);
    #1;
    compared++; if (src_ready_o !== '0) begin mismatched++; $display("FAIL reset_held_ready got %b want 0000", src_ready_o); end
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) push_beat(c, 1'b1, 32'hA0 + c);
    step();
    compared++; if (rdy_seen !== 4'b0000) begin mismatched++; $display("FAIL arb_latency_idle got %b want 0000", rdy_seen); end
    step();
    compared++; if (rdy_seen !== 4'b0001) begin mismatched++; $display("FAIL first_grant_ready got %b want 0001", rdy_seen); end
  endtask

  task automatic test_reset_arb();
    int            exp_ch [4]   = '{1, 1, 3, 3};
    bit            exp_last [4] = '{0, 1, 0, 1};
    logic [DW-1:0] exp_d [4]    = '{32'h1100_0001, 32'h1100_0002, 32'h3300_0001, 32'h3300_0002};
    do_reset();
    push_beat(1, 1'b0, 32'h1100_0001);
    push_beat(1, 1'b1, 32'h1100_0002);
    push_beat(3, 1'b0, 32'h3300_0001);
    push_beat(3, 1'b1, 32'h3300_0002);
    for (int k = 0; k < 40 && cap_ch.size() < 4; k++) step();
    compared++; if (cap_ch.size() != 4) begin mismatched++; $display("FAIL reset_arb_count got %0d want 4", cap_ch.size()); end
    for (int i = 0; i < 4 && i < cap_ch.size(); i++) begin
      compared++;
      if (cap_ch[i] != exp_ch[i] || cap_last[i] !== exp_last[i] || cap_data[i] !== exp_d[i]) begin
        mismatched++;
        $display("FAIL reset_arb[%0d] got ch%0d last%0d %h want ch%0d last%0d %h",
                 i, cap_ch[i], cap_last[i], cap_data[i], exp_ch[i], exp_last[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < N; c++) push_beat(c, 1'b1, 32'hB0 + c * 16 + n);
    for (int k = 0; k < 80 && cap_ch.size() < 8; k++) step();
    compared++; if (cap_ch.size() != 8) begin mismatched++; $display("FAIL rotation_count got %0d want 8", cap_ch.size()); end
    for (int i = 0; i < 8 && i < cap_ch.size(); i++) begin
      compared++;
      if (cap_ch[i] != i % 4 || cap_data[i] !== DW'(32'hB0 + (i % 4) * 16 + i / 4)) begin
        mismatched++;
        $display("FAIL rotation[%0d] got ch%0d %h want ch%0d", i, cap_ch[i], cap_data[i], i % 4);
      end
    end
  endtask

  task automatic test_grant_lock();
    int gap = 0;
    int exp_o [5] = '{0, 0, 0, 2, 2};
    do_reset();
    push_beat(0, 1'b0, 32'hC0_01);
    push_beat(0, 1'b0, 32'hC0_02);
    push_beat(0, 1'b1, 32'hC0_03);
    push_beat(2, 1'b0, 32'hC2_01);
    push_beat(2, 1'b1, 32'hC2_02);
    for (int k = 0; k < 60 && acc_order.size() < 5; k++) begin
      hold[0] = (acc_cnt[0] == 1) && (gap < 2);
      if (hold[0]) gap++;
      step();
    end
    hold[0] = 1'b0;
    compared++; if (acc_order.size() != 5) begin mismatched++; $display("FAIL lock_count got %0d want 5", acc_order.size()); end
    for (int i = 0; i < 5 && i < acc_order.size(); i++) begin
      compared++;
      if (acc_order[i] != exp_o[i]) begin
        mismatched++;
        $display("FAIL lock_order[%0d] got ch%0d want ch%0d", i, acc_order[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit exp_r [5] = '{0, 1, 1, 0, 0};
    do_reset();
    for (int b = 0; b < 4; b++) push_beat(1, b == 3, 32'hD000_0000 + b);
    dst_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      compared++;
      if (rdy_seen[1] !== exp_r[k]) begin mismatched++; $display("FAIL bp_ready[%0d] got %b want %b", k, rdy_seen[1], exp_r[k]); end
      if (k >= 3) begin
        compared++;
        if (dst_valid_o !== 1'b1 || dst_data_o !== 32'hD000_0000) begin
          mismatched++;
          $display("FAIL bp_stable[%0d] got v%b %h want v1 d0000000", k, dst_valid_o, dst_data_o);
        end
      end
    end
    compared++; if (cap_ch.size() != 0) begin mismatched++; $display("FAIL bp_no_pop got %0d want 0", cap_ch.size()); end
    dst_ready_i = 1'b1;
    for (int k = 0; k < 30 && cap_ch.size() < 4; k++) step();
    repeat (5) step();
    compared++; if (cap_ch.size() != 4) begin mismatched++; $display("FAIL bp_count got %0d want 4", cap_ch.size()); end
    for (int i = 0; i < 4 && i < cap_ch.size(); i++) begin
      compared++;
      if (cap_data[i] !== 32'hD000_0000 + i || cap_last[i] !== (i == 3) || cap_ch[i] != 1) begin
        mismatched++;
        $display("FAIL bp_beat[%0d] got ch%0d last%0d %h want ch1 last%0d %h",
                 i, cap_ch[i], cap_last[i], cap_data[i], i == 3, 32'hD000_0000 + i);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int b = 0; b < 4; b++) push_beat(2, b == 3, 32'hE000_0000 + b);
    dst_ready_i = 1'b0;
    repeat (4) step();
    compared++; if (dst_valid_o !== 1'b1) begin mismatched++; $display("FAIL areset_pre_valid got %b want 1", dst_valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (dst_valid_o !== 1'b0) begin mismatched++; $display("FAIL areset_dst_valid got %b want 0", dst_valid_o); end
    compared++; if (src_ready_o !== '0) begin mismatched++; $display("FAIL areset_src_ready got %b want 0000", src_ready_o); end
    clear_tb();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) push_beat(c, 1'b1, 32'hF0 + c);
    for (int k = 0; k < 40 && cap_ch.size() < 4; k++) step();
    repeat (5) step();
    compared++; if (cap_ch.size() != 4) begin mismatched++; $display("FAIL areset_count got %0d want 4", cap_ch.size()); end
    for (int i = 0; i < 4 && i < cap_ch.size(); i++) begin
      compared++;
      if (cap_ch[i] != i || cap_data[i] !== 32'hF0 + i) begin
        mismatched++;
        $display("FAIL areset_order[%0d] got ch%0d %h want ch%0d %h", i, cap_ch[i], cap_data[i], i, 32'hF0 + i);
      end
    end
  endtask

`ifdef SGDMAC_ARB_PRIO_EN
  task automatic test_prio();
    do_reset();
    src_prio_i = 4'b0100;
    push_beat(0, 1'b1, 32'h0A00);
    push_beat(2, 1'b1, 32'h0A02);
    for (int k = 0; k < 30 && cap_ch.size() < 2; k++) step();
    compared++; if (cap_ch.size() != 2) begin mismatched++; $display("FAIL prio_count got %0d want 2", cap_ch.size()); end
    if (cap_ch.size() == 2) begin
      compared++;
      if (cap_ch[0] != 2 || cap_ch[1] != 0) begin
        mismatched++;
        $display("FAIL prio_order got ch%0d,ch%0d want ch2,ch0", cap_ch[0], cap_ch[1]);
      end
    end
  endtask
`endif

  // Packet-level reference: whole packets, next non-empty channel from ptr
  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      logic [DW:0]   mq [N][$];
      int            exp_ch [$];
      logic [DW:0]   exp_b [$];
      int            ptr = 0;
      int            left = 0;
      do_reset();
      gap_en = 1'b1;
      for (int c = 0; c < N; c++) begin
        int np = $urandom_range(0, 4);
        for (int p = 0; p < np; p++) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_beat(c, b == len - 1, $urandom);
        end
        mq[c] = srcq[c];
        left += mq[c].size();
      end
      while (left > 0) begin
        int  sel = -1;
        bit  done = 1'b0;
        for (int i = 0; i < N; i++)
          if (sel < 0 && mq[(ptr + i) % N].size() > 0) sel = (ptr + i) % N;
        while (!done) begin
          logic [DW:0] bt;
          bt = mq[sel].pop_front();
          exp_ch.push_back(sel);
          exp_b.push_back(bt);
          left--;
          done = bt[DW];
        end
        ptr = (sel + 1) % N;
      end
      for (int k = 0; k < 3000 && cap_ch.size() < exp_ch.size(); k++) begin
        dst_ready_i = ($urandom_range(0, 3) != 0);
        step();
      end
      dst_ready_i = 1'b1;
      repeat (5) step();
      compared++;
      if (cap_ch.size() != exp_ch.size()) begin
        mismatched++;
        $display("FAIL rand%0d_count got %0d want %0d", round, cap_ch.size(), exp_ch.size());
      end
      for (int i = 0; i < exp_ch.size() && i < cap_ch.size(); i++) begin
        logic [DW:0] eb;
        eb = exp_b[i];
        compared++;
        if (cap_ch[i] != exp_ch[i] || cap_last[i] !== eb[DW] || cap_data[i] !== eb[DW-1:0]) begin
          mismatched++;
          $display("FAIL rand%0d[%0d] got ch%0d last%0d %h want ch%0d last%0d %h",
                   round, i, cap_ch[i], cap_last[i], cap_data[i], exp_ch[i], eb[DW], eb[DW-1:0]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_arb();
    test_rotation();
    test_grant_lock();
    test_backpressure();
    test_async_reset();
`ifdef SGDMAC_ARB_PRIO_EN
    test_prio();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
